// File: rtl/id_ex_operand_stage.sv
// ID/EX operand register feeding the ALU: resolves RAW hazards by forwarding at capture,
// applies the immediate select, and holds or drains under a valid/ready handshake.
module id_ex_operand_stage #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    rs1_val,
  input  logic [XLEN-1:0]    rs2_val,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic               rd_we,
  input  logic [XLEN-1:0]    imm,
  input  logic               use_imm,
  input  logic [2:0]         alu_sel_in,
  input  logic [5:0]         shamt_in,
  input  logic               exmem_we,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_we,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]    memwb_result,
  input  logic               flush,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [XLEN-1:0]    A,
  output logic [XLEN-1:0]    B,
  output logic [5:0]         Shiftamt,
  output logic [2:0]         Sel,
  output logic [RADDR_W-1:0] out_rd_addr,
  output logic               out_rd_we,
  output logic               illegal_op
);

  // EX/MEM wins over MEM/WB; register x0 never forwards.
  function automatic logic [XLEN-1:0] forward_sel(
    input logic [RADDR_W-1:0] rs,
    input logic [XLEN-1:0]    rf_val,
    input logic               ex_we,
    input logic [RADDR_W-1:0] ex_rd,
    input logic [XLEN-1:0]    ex_res,
    input logic               wb_we,
    input logic [RADDR_W-1:0] wb_rd,
    input logic [XLEN-1:0]    wb_res
  );
    logic [XLEN-1:0] r;
    if (ex_we && (ex_rd == rs) && (rs != {RADDR_W{1'b0}})) begin
      r = ex_res;
    end else if (wb_we && (wb_rd == rs) && (rs != {RADDR_W{1'b0}})) begin
      r = wb_res;
    end else begin
      r = rf_val;
    end
    return r;
  endfunction

  logic [XLEN-1:0] a_next;
  logic [XLEN-1:0] b_next;
  logic [2:0]      sel_next;
  logic            sel_illegal;
  logic            capture;

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready;

  always_comb begin
    a_next      = forward_sel(rs1_addr, rs1_val, exmem_we, exmem_rd, exmem_result,
                              memwb_we, memwb_rd, memwb_result);
    b_next      = forward_sel(rs2_addr, rs2_val, exmem_we, exmem_rd, exmem_result,
                              memwb_we, memwb_rd, memwb_result);
    sel_illegal = (alu_sel_in == 3'b111);
    if (use_imm) begin
      b_next = imm;
    end else begin
      b_next = b_next;
    end
    if (sel_illegal) begin
      sel_next = 3'b000;
    end else begin
      sel_next = alu_sel_in;
    end
  end

  // Pipeline register: reset, then flush, then capture, then drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      A           <= {XLEN{1'b0}};
      B           <= {XLEN{1'b0}};
      Shiftamt    <= 6'd0;
      Sel         <= 3'b000;
      out_rd_addr <= {RADDR_W{1'b0}};
      out_rd_we   <= 1'b0;
      illegal_op  <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_rd_we   <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      A           <= a_next;
      B           <= b_next;
      Shiftamt    <= shamt_in;
      Sel         <= sel_next;
      out_rd_addr <= rd_addr;
      out_rd_we   <= rd_we;
      illegal_op  <= illegal_op | sel_illegal;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
      out_rd_we   <= 1'b0;
    end else begin
      out_valid   <= out_valid;
      out_rd_we   <= out_rd_we;
    end
  end

endmodule
